// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeper: BCD MM:SS.cc advanced by the 100 Hz divider output, sampled as data in clk_in.
// Start/stop, lap freeze and clear controls; registered display value for the digit multiplexer.
//
// state | meaning
// IDLE  | count zero, stopped
// RUN   | counting on every tick
// PAUSE | stopped, count retained
`timescale 1ns/1ps
module stopwatch_counter #(
  parameter bit ROLL_OVER = 1'b1,
  parameter int MAX_MIN   = 59
) (
  input  logic        clk_in,
  input  logic        res,
  input  logic        ena,
  input  logic        div_in,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [3:0]  MAX_MT    = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_MU    = 4'(MAX_MIN % 10);
  localparam logic [23:0] COUNT_MAX = {MAX_MT, MAX_MU, 4'd5, 4'd9, 4'd9, 4'd9};

  state_t      state;
  state_t      state_nxt;
  logic        div_q;
  logic        ss_q;
  logic        lap_q;
  logic        clr_q;
  logic        tick;
  logic        ss_edge;
  logic        lap_edge;
  logic        clr_edge;
  logic        at_max;
  logic [23:0] count;
  logic [23:0] count_inc;
  logic [23:0] snapshot;

  assign tick     = div_in & ~div_q;
  assign ss_edge  = start_stop & ~ss_q;
  assign lap_edge = lap & ~lap_q;
  assign clr_edge = clear & ~clr_q;
  assign at_max   = (count == COUNT_MAX);

  // Nibbles, MSB first: min_t, min_u, sec_t, sec_u, cs_t, cs_u; every carry resolves in one cycle.
  always_comb begin
    count_inc = count;
    if (count[3:0] != 4'd9) begin
      count_inc[3:0] = count[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count[7:4] != 4'd9) begin
        count_inc[7:4] = count[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count[11:8] != 4'd9) begin
          count_inc[11:8] = count[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count[15:12] != 4'd5) begin
            count_inc[15:12] = count[15:12] + 4'd1;
          end else begin
            count_inc[15:12] = 4'd0;
            if (count[19:16] != 4'd9) begin
              count_inc[19:16] = count[19:16] + 4'd1;
            end else begin
              count_inc[19:16] = 4'd0;
              count_inc[23:20] = count[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Saturation and start_stop both act on the pre-transition state.
  always_comb begin
    state_nxt = state;
    if (!ROLL_OVER && state == RUN && tick && at_max) begin
      state_nxt = PAUSE;
    end
    if (ss_edge) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (res) begin
      div_q      <= 1'b0;
      ss_q       <= 1'b0;
      lap_q      <= 1'b0;
      clr_q      <= 1'b0;
      state      <= IDLE;
      running    <= 1'b0;
      count      <= '0;
      snapshot   <= '0;
      digits     <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      div_q  <= div_in;
      ss_q   <= start_stop;
      lap_q  <= lap;
      clr_q  <= clear;
      digits <= lap_active ? snapshot : count;
      if (clr_edge) begin
        state      <= IDLE;
        running    <= 1'b0;
        count      <= '0;
        lap_active <= 1'b0;
        overflow   <= 1'b0;
      end else if (ena) begin
        state   <= state_nxt;
        running <= (state_nxt == RUN);
        if (state == RUN && tick) begin
          if (!at_max) begin
            count <= count_inc;
          end else begin
            overflow <= 1'b1;
            if (ROLL_OVER) begin
              count <= '0;
            end
          end
        end
        // Snapshot takes the pre-increment count when a tick lands in the same cycle.
        if (lap_edge && state != IDLE) begin
          lap_active <= ~lap_active;
          if (!lap_active) begin
            snapshot <= count;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: cycle table, directed corner sequences and randomized run vs an
// integer-centisecond reference model, on default and MAX_MIN=1 roll-over/saturate instances.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  logic clk_in = 1'b0;
  logic res = 1'b1, ena = 1'b1, div_in = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [23:0] dig_m, dig_r, dig_s;
  logic run_m, run_r, run_s, lap_m, lap_r, lap_s, ovf_m, ovf_r, ovf_s;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  stopwatch_counter dut_m (
    .clk_in(clk_in), .res(res), .ena(ena), .div_in(div_in), .start_stop(start_stop),
    .lap(lap), .clear(clear), .digits(dig_m), .running(run_m), .lap_active(lap_m),
    .overflow(ovf_m));

  stopwatch_counter #(.ROLL_OVER(1'b1), .MAX_MIN(1)) dut_r (
    .clk_in(clk_in), .res(res), .ena(ena), .div_in(div_in), .start_stop(start_stop),
    .lap(lap), .clear(clear), .digits(dig_r), .running(run_r), .lap_active(lap_r),
    .overflow(ovf_r));

  stopwatch_counter #(.ROLL_OVER(1'b0), .MAX_MIN(1)) dut_s (
    .clk_in(clk_in), .res(res), .ena(ena), .div_in(div_in), .start_stop(start_stop),
    .lap(lap), .clear(clear), .digits(dig_s), .running(run_s), .lap_active(lap_s),
    .overflow(ovf_s));

  // Reference model: elapsed time as plain centiseconds; st 0=idle 1=run 2=pause.
  typedef struct {
    int cnt; int snap; int shown; int st;
    bit lapa; bit ovf; bit pd; bit ps; bit pl; bit pc;
  } mdl_t;

  mdl_t mm, mr, ms;

  function automatic mdl_t step(mdl_t m, logic r, logic e, logic d, logic s, logic l, logic c,
                                int max_min, bit roll);
    mdl_t n;
    int limit;
    bit tk, se, le, ce;
    n = m;
    limit = max_min * 6000 + 5999;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    tk = d && !m.pd;
    se = s && !m.ps;
    le = l && !m.pl;
    ce = c && !m.pc;
    n.pd = d; n.ps = s; n.pl = l; n.pc = c;
    n.shown = m.lapa ? m.snap : m.cnt;
    if (ce) begin
      n.st = 0; n.cnt = 0; n.lapa = 0; n.ovf = 0;
    end else if (e) begin
      if (m.st == 1 && tk) begin
        if (m.cnt < limit) n.cnt = m.cnt + 1;
        else begin
          n.ovf = 1;
          if (roll) n.cnt = 0;
          else n.st = 2;
        end
      end
      if (se) n.st = (m.st == 1) ? 2 : 1;
      if (le && m.st != 0) begin
        n.lapa = !m.lapa;
        if (!m.lapa) n.snap = m.cnt;
      end
    end
    return n;
  endfunction

  function automatic logic [23:0] bcd(int cs);
    int mi, se, cc;
    mi = cs / 6000;
    se = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  always @(posedge clk_in) begin
    mm <= step(mm, res, ena, div_in, start_stop, lap, clear, 59, 1'b1);
    mr <= step(mr, res, ena, div_in, start_stop, lap, clear, 1, 1'b1);
    ms <= step(ms, res, ena, div_in, start_stop, lap, clear, 1, 1'b0);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      div_in = 1'b1; step_clk();
      div_in = 1'b0; step_clk();
    end
  endtask

  // which: 0 start_stop, 1 lap, 2 clear
  task automatic pulse(int which);
    case (which)
      0: start_stop = 1'b1;
      1: lap = 1'b1;
      default: clear = 1'b1;
    endcase
    step_clk();
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step_clk();
  endtask

  typedef struct {
    logic r, e, d, s, l, c;
    logic [23:0] dig;
    logic run, lp, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic e, logic d, logic s, logic l, logic c,
                             logic [23:0] dig, logic run, logic lp, logic ov);
    vec_t x;
    x.r = r; x.e = e; x.d = d; x.s = s; x.l = l; x.c = c;
    x.dig = dig; x.run = run; x.lp = lp; x.ov = ov;
    return x;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           res ena div ss lap clr   digits    run lap ovf
    tbl.push_back(v(1, 1, 1, 1, 1, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 24'h000000, 1, 0, 0)); // high at release -> edge
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000000, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 24'h000001, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000001, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000002, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 24'h000002, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000002, 0, 0, 0)); // tick + stop together
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 24'h000003, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000003, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000003, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 24'h000003, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000003, 1, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 24'h000003, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000003, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 24'h000003, 1, 1, 0)); // tick lost while disabled
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000003, 1, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000003, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000004, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 1, 1, 24'h000004, 0, 0, 0)); // clear + tick
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 24'h000000, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000000, 0, 0, 0)); // lap ignored in IDLE
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000000, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 24'h000000, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 24'h000001, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 24'h000001, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 24'h000001, 0, 0, 0)); // clear + start_stop
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 24'h000000, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 24'h000000, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 0, 24'h000001, 1, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 1, 1, 24'h000000, 0, 0, 0)); // reset mid-run

    // Reset held two cycles with inputs toggling
    for (int i = 0; i < 2; i++) begin
      res = 1'b1;
      ena = 1'($urandom);
      {div_in, start_stop, lap, clear} = 4'($urandom);
      step_clk();
    end
    chk("reset digits", 32'(dig_m), 32'h0);
    chk("reset flags", 32'({run_m, lap_m, ovf_m}), 32'h0);

    foreach (tbl[i]) begin
      res = tbl[i].r; ena = tbl[i].e; div_in = tbl[i].d;
      start_stop = tbl[i].s; lap = tbl[i].l; clear = tbl[i].c;
      step_clk();
      chk($sformatf("table row %0d digits", i), 32'(dig_m), 32'(tbl[i].dig));
      chk($sformatf("table row %0d flags", i), 32'({run_m, lap_m, ovf_m}),
          32'({tbl[i].run, tbl[i].lp, tbl[i].ov}));
    end

    res = 1'b0; ena = 1'b1; div_in = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    step_clk();

    pulse(0);
    tick_n(150);
    chk("150 ticks digits", 32'(dig_m), 32'h000150);
    chk("150 ticks running", 32'(run_m), 32'h1);

    pulse(2); pulse(0);
    tick_n(25); pulse(0); tick_n(40);
    chk("pause digits", 32'(dig_m), 32'h000025);
    chk("pause running", 32'(run_m), 32'h0);
    pulse(0); tick_n(5);
    chk("resume digits", 32'(dig_m), 32'h000030);

    pulse(2); pulse(0);
    tick_n(300); pulse(1); tick_n(200);
    chk("lap frozen digits", 32'(dig_m), 32'h000300);
    chk("lap active", 32'(lap_m), 32'h1);
    pulse(1);
    chk("lap release digits", 32'(dig_m), 32'h000500);
    chk("lap released", 32'(lap_m), 32'h0);

    ena = 1'b0; tick_n(50); ena = 1'b1;
    chk("ena low holds count", 32'(dig_m), 32'h000500);
    tick_n(1);
    chk("ena restored counts", 32'(dig_m), 32'h000501);

    pulse(2); pulse(0);
    tick_n(5999);
    chk("at 00:59.99", 32'(dig_m), 32'h005999);
    div_in = 1'b1; step_clk();
    chk("carry latency", 32'(dig_m), 32'h005999);
    div_in = 1'b0; step_clk();
    chk("carry to minute", 32'(dig_m), 32'h010000);

    tick_n(5999);
    chk("roll inst at max", 32'(dig_r), 32'h015999);
    chk("sat inst at max", 32'(dig_s), 32'h015999);
    tick_n(1);
    chk("main past 1 min", 32'(dig_m), 32'h020000);
    chk("roll wraps", 32'(dig_r), 32'h000000);
    chk("roll flags", 32'({run_r, ovf_r}), 32'b11);
    chk("sat holds", 32'(dig_s), 32'h015999);
    chk("sat flags", 32'({run_s, ovf_s}), 32'b01);
    tick_n(3);
    chk("roll keeps running", 32'(dig_r), 32'h000003);
    chk("sat stays held", 32'(dig_s), 32'h015999);

    tick_n(1231);
    chk("roll at 00:12.34", 32'({dig_r, ovf_r}), 32'({24'h001234, 1'b1}));
    clear = 1'b1; div_in = 1'b1; step_clk();
    clear = 1'b0; div_in = 1'b0; step_clk();
    chk("clear with tick digits", 32'(dig_r), 32'h000000);
    chk("clear with tick flags", 32'({run_r, lap_r, ovf_r}), 32'h0);
    chk("clear sat ovf", 32'({dig_s, ovf_s}), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      res = ($urandom_range(0, 299) == 0);
      ena = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 1) == 1) div_in = ~div_in;
      if ($urandom_range(0, 39) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 29) == 0) lap = ~lap;
      if ($urandom_range(0, 149) == 0) clear = ~clear;
      step_clk();
      chk("random main", 32'({dig_m, run_m, lap_m, ovf_m}),
          32'({bcd(mm.shown), mm.st == 1, mm.lapa, mm.ovf}));
      chk("random roll", 32'({dig_r, run_r, lap_r, ovf_r}),
          32'({bcd(mr.shown), mr.st == 1, mr.lapa, mr.ovf}));
      chk("random sat", 32'({dig_s, run_s, lap_s, ovf_s}),
          32'({bcd(ms.shown), ms.st == 1, ms.lapa, ms.ovf}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
